// File: rtl/bitty_fetch_unit_if.sv
// Bus between the bitty fetch unit and its neighbours: the synchronous
// instruction memory read port and the execution-core issue handshake.
// The fetch unit is the master; memory and core together form the slave side.
interface bitty_fetch_unit_if #(
  parameter int ADDR_WIDTH = 8
);
  // Instruction memory read port
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rd_en;
  logic [15:0]           mem_rdata;
  logic                  mem_valid;

  // Core issue handshake
  logic [15:0]           instruction;
  logic                  run;
  logic                  done;

  modport master (
    output mem_addr,
    output mem_rd_en,
    input  mem_rdata,
    input  mem_valid,
    output instruction,
    output run,
    input  done
  );

  modport slave (
    input  mem_addr,
    input  mem_rd_en,
    output mem_rdata,
    output mem_valid,
    input  instruction,
    input  run,
    output done
  );
endinterface

// File: rtl/bitty_fetch_unit.sv
// bitty_fetch_unit: instruction-issue initiator for the bitty execution core.
// Fetches 16-bit words from a synchronous instruction memory, presents each
// to the core with run held high until done is accepted, then advances pc
// from start_addr to end_addr (wrapping modulo 2**ADDR_WIDTH).
// Optional feature macro: BITTY_FETCH_PERF_EN adds the retired_count output.
module bitty_fetch_unit #(
  parameter int ADDR_WIDTH = 8,
  parameter int MIN_EXEC   = 3   // must be >= 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  halt_req,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH-1:0] end_addr,
  bitty_fetch_unit_if.master    bus,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  busy,
  output logic                  finished
`ifdef BITTY_FETCH_PERF_EN
  ,
  output logic [15:0]           retired_count
`endif
);

  // exec_cnt counts completed run cycles and saturates at MIN_EXEC.
  localparam int CNT_W = $clog2(MIN_EXEC + 1);
  localparam logic [CNT_W-1:0] EXEC_SAT  = CNT_W'(MIN_EXEC);
  // done is accepted in the run cycle that completes MIN_EXEC cycles,
  // i.e. when MIN_EXEC-1 earlier run cycles have already been counted.
  localparam logic [CNT_W-1:0] EXEC_LAST = CNT_W'(MIN_EXEC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_MEM,
    S_ISSUE,
    S_RETIRE
  } state_t;

  state_t                state, next_state;
  logic [ADDR_WIDTH-1:0] end_r;
  logic [15:0]           instr_r;
  logic [CNT_W-1:0]      exec_cnt;
  logic                  halt_seen;

  logic                  start_ok;
  logic                  mem_capture;
  logic                  accept;
  logic                  seq_end;
  logic                  rd_en_c;
  logic                  run_c;
  logic                  busy_c;
  logic                  finished_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= EXEC_SAT) ? v : v + CNT_W'(1);
  endfunction

  assign start_ok    = (state == S_IDLE) && start;
  assign mem_capture = (state == S_WAIT_MEM) && bus.mem_valid;
  assign accept      = (state == S_ISSUE) && (exec_cnt >= EXEC_LAST) && bus.done;
  assign seq_end     = (pc == end_r) || halt_seen;

  // State register; async reset forces IDLE so run drops immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and state-derived control outputs.
  always_comb begin
    next_state = state;
    rd_en_c    = 1'b0;
    run_c      = 1'b0;
    busy_c     = 1'b1;
    finished_c = 1'b0;
    case (state)
      S_IDLE: begin
        busy_c = 1'b0;
        if (start) next_state = S_FETCH;
      end
      S_FETCH: begin
        rd_en_c    = 1'b1;
        next_state = S_WAIT_MEM;
      end
      S_WAIT_MEM: begin
        if (bus.mem_valid) next_state = S_ISSUE;
      end
      S_ISSUE: begin
        run_c = 1'b1;
        if (accept) next_state = S_RETIRE;
      end
      S_RETIRE: begin
        if (seq_end) begin
          finished_c = 1'b1;
          next_state = S_IDLE;
        end else begin
          next_state = S_FETCH;
        end
      end
      default: begin
        busy_c     = 1'b0;
        next_state = S_IDLE;
      end
    endcase
  end

  // Program counter and end-address latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc    <= '0;
      end_r <= '0;
    end else if (start_ok) begin
      pc    <= start_addr;
      end_r <= end_addr;
    end else if ((state == S_RETIRE) && !seq_end) begin
      pc    <= pc + ADDR_WIDTH'(1);
    end
  end

  // Instruction capture and minimum-execution counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_r  <= '0;
      exec_cnt <= '0;
    end else if (mem_capture) begin
      instr_r  <= bus.mem_rdata;
      exec_cnt <= '0;
    end else if (state == S_ISSUE) begin
      exec_cnt <= sat_inc(exec_cnt);
    end
  end

  // Halt request latch: armed in busy states, consumed when the sequence ends.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halt_seen <= 1'b0;
    end else if (start_ok || ((state == S_RETIRE) && seq_end)) begin
      halt_seen <= 1'b0;
    end else if ((state != S_IDLE) && halt_req) begin
      halt_seen <= 1'b1;
    end
  end

`ifdef BITTY_FETCH_PERF_EN
  // Retired-instruction counter; clears on each accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_count <= '0;
    end else if (start_ok) begin
      retired_count <= '0;
    end else if (state == S_RETIRE) begin
      retired_count <= retired_count + 16'd1;
    end
  end
`endif

  assign bus.mem_addr    = pc;
  assign bus.mem_rd_en   = rd_en_c;
  assign bus.instruction = instr_r;
  assign bus.run         = run_c;
  assign busy            = busy_c;
  assign finished        = finished_c;

endmodule
